// File: rtl/icache_plru.sv
// icache_plru: per-set 8-way tree-PLRU victim selector; `ICACHE_PLRU_INVALID_FIRST_EN adds invalid-way-first selection
module icache_plru #(
  parameter int SETS = 64,
  parameter int WAYS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    replace2plru_valid,
  input  logic [$clog2(SETS)-1:0] replace2plru_index,
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
  input  logic [WAYS-1:0]         replace2plru_vld_mask,
`endif
  output logic [2:0]              plru2replace_way,
  output logic                    plru2replace_valid,
  input  logic                    replace2plru_ready,
  input  logic                    ctrl2plru_hit_valid,
  input  logic [$clog2(SETS)-1:0] ctrl2plru_hit_index,
  input  logic [2:0]              ctrl2plru_hit_way
);
  localparam int IW = $clog2(SETS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  logic [0:0] state;
  logic [6:0] tree [SETS];
  logic [IW-1:0] lat_idx;
  logic commit, accept;
  logic [6:0] hit_new, com_base, com_new, req_hit, req_bits;
  logic [2:0] tree_victim, victim_sel;
  function automatic logic [6:0] touch(input logic [6:0] b, input logic [2:0] w);
    logic [6:0] t;
    t = b;
    t[0] = ~w[2];
    t[w[2] ? 3'd2 : 3'd1] = ~w[1];
    t[3'd3 + {1'b0, w[2:1]}] = ~w[0];
    return t;
  endfunction
  function automatic logic [2:0] victim(input logic [6:0] b);
    logic v2, v1;
    v2 = b[0];
    v1 = v2 ? b[2] : b[1];
    return {v2, v1, b[3'd3 + {1'b0, v2, v1}]};
  endfunction
  assign commit = (state == RESP) && replace2plru_ready;
  assign accept = replace2plru_valid && ((state == IDLE) || commit);
  // Hit lands before commit, so a bit touched by both ends with the commit value.
  always_comb begin
    hit_new  = touch(tree[ctrl2plru_hit_index], ctrl2plru_hit_way);
    com_base = (ctrl2plru_hit_valid && ctrl2plru_hit_index == lat_idx) ? hit_new : tree[lat_idx];
    com_new  = touch(com_base, plru2replace_way);
    req_hit  = (ctrl2plru_hit_valid && ctrl2plru_hit_index == replace2plru_index) ? touch(tree[replace2plru_index], ctrl2plru_hit_way) : tree[replace2plru_index];
    req_bits = (commit && lat_idx == replace2plru_index) ? touch(req_hit, plru2replace_way) : req_hit;
    tree_victim = victim(req_bits);
    victim_sel  = tree_victim;
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    for (int i = WAYS - 1; i >= 0; i--)
      if (!replace2plru_vld_mask[i]) victim_sel = 3'(i);
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      plru2replace_way   <= '0;
      plru2replace_valid <= 1'b0;
      lat_idx            <= '0;
      for (int i = 0; i < SETS; i++) tree[i] <= '0;
    end else begin
      if (ctrl2plru_hit_valid) tree[ctrl2plru_hit_index] <= hit_new;
      if (commit) tree[lat_idx] <= com_new;
      if (accept) begin
        state              <= RESP;
        lat_idx            <= replace2plru_index;
        plru2replace_way   <= victim_sel;
        plru2replace_valid <= 1'b1;
      end else if (commit) begin
        state              <= IDLE;
        plru2replace_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_plru.sv
// tb_icache_plru: scoreboard bench for icache_plru; expected victims queued at request, checked at commit
module tb_icache_plru;
  logic clock = 1'b0;
  logic reset;
  logic replace2plru_valid, replace2plru_ready;
  logic [5:0] replace2plru_index;
  logic [2:0] plru2replace_way;
  logic plru2replace_valid;
  logic ctrl2plru_hit_valid;
  logic [5:0] ctrl2plru_hit_index;
  logic [2:0] ctrl2plru_hit_way;
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
  logic [7:0] replace2plru_vld_mask = 8'hFF;
`endif
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];
  logic [2:0] exp_w;
  icache_plru dut (
    .clock(clock), .reset(reset),
    .replace2plru_valid(replace2plru_valid), .replace2plru_index(replace2plru_index),
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    .replace2plru_vld_mask(replace2plru_vld_mask),
`endif
    .plru2replace_way(plru2replace_way), .plru2replace_valid(plru2replace_valid),
    .replace2plru_ready(replace2plru_ready),
    .ctrl2plru_hit_valid(ctrl2plru_hit_valid), .ctrl2plru_hit_index(ctrl2plru_hit_index),
    .ctrl2plru_hit_way(ctrl2plru_hit_way)
  );
  always #5 clock = ~clock;
  // Monitor: every committed response is matched against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && replace2plru_ready) begin
      checks++;
      if (!plru2replace_valid) begin
        errors++;
        $display("FAIL resp_valid: valid=%0b required=1", plru2replace_valid);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_extra: way=%0d with no expected response", plru2replace_way);
      end else begin
        exp_w = exp_q.pop_front();
        if (plru2replace_way !== exp_w) begin
          errors++;
          $display("FAIL resp_way: way=%0d required=%0d", plru2replace_way, exp_w);
        end
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic request(input logic [5:0] idx, input logic [2:0] exp);
    replace2plru_valid = 1'b1;
    replace2plru_index = idx;
    exp_q.push_back(exp);
    step();
    replace2plru_valid = 1'b0;
  endtask
  task automatic commit_only();
    replace2plru_ready = 1'b1;
    step();
    replace2plru_ready = 1'b0;
  endtask
  task automatic txn(input logic [5:0] idx, input logic [2:0] exp);
    request(idx, exp);
    commit_only();
  endtask
  task automatic hit(input logic [5:0] idx, input logic [2:0] w);
    ctrl2plru_hit_valid = 1'b1;
    ctrl2plru_hit_index = idx;
    ctrl2plru_hit_way = w;
    step();
    ctrl2plru_hit_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    logic [2:0] seq9 [9];
    seq9 = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
    reset = 1'b1;
    replace2plru_valid = 1'b0;
    replace2plru_ready = 1'b0;
    replace2plru_index = '0;
    ctrl2plru_hit_valid = 1'b0;
    ctrl2plru_hit_index = '0;
    ctrl2plru_hit_way = '0;
    step();
    step();
    reset = 1'b0;
    check("reset_valid", {3'b0, plru2replace_valid}, 4'd0);
    check("reset_way", {1'b0, plru2replace_way}, 4'd0);
    txn(6'd5, 3'd0);
    txn(6'd5, 3'd4);
    for (int i = 0; i < 9; i++) txn(6'd9, seq9[i]);
    check("idle_after_commit", {3'b0, plru2replace_valid}, 4'd0);
    hit(6'd3, 3'd0);
    txn(6'd3, 3'd4);
    txn(6'd4, 3'd0);
    request(6'd7, 3'd0);
    replace2plru_ready = 1'b1;
    request(6'd7, 3'd4);
    check("b2b_valid", {3'b0, plru2replace_valid}, 4'd1);
    commit_only();
    do_reset();
    request(6'd2, 3'd0);
    replace2plru_ready = 1'b1;
    hit(6'd2, 3'd4);
    replace2plru_ready = 1'b0;
    txn(6'd2, 3'd6);
    replace2plru_valid = 1'b1;
    replace2plru_index = 6'd5;
    step();
    replace2plru_valid = 1'b0;
    check("pre_reset_valid", {3'b0, plru2replace_valid}, 4'd1);
    do_reset();
    check("mid_reset_valid", {3'b0, plru2replace_valid}, 4'd0);
    check("mid_reset_way", {1'b0, plru2replace_way}, 4'd0);
    txn(6'd5, 3'd0);
`ifdef ICACHE_PLRU_INVALID_FIRST_EN
    replace2plru_vld_mask = 8'b1111_0111;
    txn(6'd10, 3'd3);
    replace2plru_vld_mask = 8'hFF;
    txn(6'd10, 3'd4);
`endif
    repeat (3) step();
    check("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/icache_plru.md
Name: icache_plru

Overview:
- Per-set 8-way tree-PLRU victim selector for the 64-set icache.
- Responder end of the replace↔plru interface: accepts a victim request (valid + index) from the replace unit and returns a registered victim way one cycle later.
- Updates replacement state when the replacement commits (ready) and on icache hits reported by ctrl.

Parameters:
- SETS, 64, number of sets; index width is log2(SETS) = 6.
- WAYS, 8, associativity; fixed at 8, giving 7 tree bits per set.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- replace2plru_valid  input  1  victim request strobe
- replace2plru_index  input  6  set index of the request
- plru2replace_way  output  3  victim way; registered and stable while plru2replace_valid=1
- plru2replace_valid  output  1  victim way valid (RESP state)
- replace2plru_ready  input  1  replacement committed; consumes the response
- ctrl2plru_hit_valid  input  1  hit-update strobe
- ctrl2plru_hit_index  input  6  set index of the hit
- ctrl2plru_hit_way  input  3  way that hit

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-high, named reset.
- Reset values: plru2replace_way=0, plru2replace_valid=0, FSM=IDLE, all 64×7 tree bits=0.
- Tree encoding per set, bits b[0..6]:
  - b0 is the root; b1/b2 are level 1; b3..b6 are level 2.
  - Bit value 0 points to the lower half, 1 to the upper half.
- Victim computation:
  - v2 = b0
  - v1 = b[1+v2]
  - v0 = b[3+2*v2+v1]
- Touch way w (mark MRU):
  - b0 = ~w[2]
  - b[1+w[2]] = ~w[1]
  - b[3+2*w[2]+w[1]] = ~w[0]
  - The other 4 bits are unchanged.
- FSM:
  - IDLE: on replace2plru_valid, latch the index, compute the victim from that set's tree, register it into plru2replace_way, set plru2replace_valid=1, go to RESP. Latency is 1 cycle from valid to way.
  - RESP: plru2replace_way and plru2replace_valid are held stable. replace2plru_valid alone is ignored.
  - RESP with replace2plru_ready: touch the latched set with the latched way (victim becomes MRU).
    - If replace2plru_valid is not also asserted: return to IDLE and drop valid next cycle.
    - If replace2plru_valid is asserted in the same cycle (back-to-back): stay in RESP. The new victim is computed from post-update tree bits, with forwarding when the index matches the committing set.
  - replace2plru_ready in IDLE: no effect.
- Hit update:
  - ctrl2plru_hit_valid touches (hit_index, hit_way) at the clock edge, in any state.
  - Hit and commit to the same set in the same cycle: apply the hit first, then the commit. A bit written by both takes the commit value.
  - Hit and commit to different sets: both apply.
  - A new request in the same cycle as any update to its set sees the combined post-update bits.
- A hit to the latched set while in RESP does not change the already-registered plru2replace_way.
- Reset asserted mid-RESP: next cycle plru2replace_valid=0, way=0, FSM=IDLE, all trees cleared. The pending commit is discarded.

Optional Feature:
- Macro: ICACHE_PLRU_INVALID_FIRST_EN.
- When defined:
  - Adds input replace2plru_vld_mask[7:0], sampled together with replace2plru_valid (1 = way holds valid data).
  - If any mask bit is 0, the victim is the lowest-numbered invalid way; otherwise the tree victim is used.
  - The commit still touches the returned way.
- When undefined: the port is absent and the victim is always the tree victim.

Test Plan:
- Reset; request idx 5 → way 0 one cycle later with valid=1. Assert ready, then request idx 5 → way 4.
- Eight consecutive request/commit pairs on idx 9 → ways 0,4,2,6,1,5,3,7; a ninth request → 0.
- Cross-set isolation:
  - Hit (idx 3, way 0), then request idx 3 → way 4.
  - Request idx 4 → way 0, since other sets are unaffected.
- Back-to-back: in RESP (idx 7, way 0), assert ready + valid(idx 7) in one cycle → valid stays 1, next way = 4.
- Same-set conflict: from reset, same cycle hit (idx 2, way 4) and commit (idx 2, way 0) → next request idx 2 returns way 6.
- Reset during RESP → valid=0 and way=0 next cycle. Request idx 5 → way 0.
- With ICACHE_PLRU_INVALID_FIRST_EN:
  - mask=8'b1111_0111 → way 3.
  - mask=8'hFF → tree victim.
